// File: rtl/jmb_interp_pkg.sv
// Shared definitions for the interpolation line controller: FSM encoding and
// the default counter width.
package jmb_interp_pkg;

    localparam int unsigned WB_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRIME    = 3'd1,
        ST_RUN      = 3'd2,
        ST_FLUSH1   = 3'd3,
        ST_FLUSH2   = 3'd4,
        ST_LINE_END = 3'd5
    } state_t;

endpackage

// File: rtl/jmb_interp_line_cnt.sv
// Pixel/line counters with latched frame geometry and terminal-count flags
// for the interpolation line controller.
module jmb_interp_line_cnt #(
    parameter int unsigned WB = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_load,
    input  logic [WB-1:0] i_cfg_w,
    input  logic [WB-1:0] i_cfg_h,
    input  logic          i_pix_inc,
    input  logic          i_line_inc,
    output logic          o_pix_one,
    output logic          o_pix_tc,
    output logic          o_line_tc
);

    logic [WB-1:0] r_cfg_w;
    logic [WB-1:0] r_cfg_h;
    logic [WB-1:0] r_pix_cnt;
    logic [WB-1:0] r_line_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cfg_w    <= '0;
            r_cfg_h    <= '0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (i_load) begin
            r_cfg_w    <= i_cfg_w;
            r_cfg_h    <= i_cfg_h;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (i_line_inc) begin
            r_line_cnt <= r_line_cnt + WB'(1);
            r_pix_cnt  <= '0;
        end else if (i_pix_inc) begin
            r_pix_cnt  <= r_pix_cnt + WB'(1);
        end
    end

    // Flags describe the pixel/line being accepted/closed this cycle.
    assign o_pix_one = (r_pix_cnt == WB'(1));
    assign o_pix_tc  = ((r_pix_cnt + WB'(1)) == r_cfg_w);
    assign o_line_tc = ((r_line_cnt + WB'(1)) == r_cfg_h);

endmodule

// File: rtl/jmb_interp_line_ctrl.sv
// Line controller feeding a 2x horizontal interpolation datapath: primes two
// pixels, streams the line, then flushes twice to emit cfg_width pairs per line.
module jmb_interp_line_ctrl
    import jmb_interp_pkg::*;
#(
    parameter int unsigned WB = WB_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [WB-1:0] cfg_width,
    input  logic [WB-1:0] cfg_height,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    output logic          dp_valid,
    output logic          dp_ready,
    output logic [7:0]    dp_data,
    input  logic          m_ready,
    output logic          m_valid,
    output logic          m_first,
    output logic          m_last,
    output logic          busy,
    output logic          frame_done,
    output logic          cfg_err
);

    state_t     r_state;
    state_t     w_next;
    logic       w_cfg_ok;
    logic       w_load;
    logic       w_accept;
    logic       w_fire;
    logic       w_produce;
    logic       w_done;
    logic       w_line_inc;
    logic       w_pix_one;
    logic       w_pix_tc;
    logic       w_line_tc;
    logic [7:0] r_hold;
    logic       r_first_pend;

    assign w_cfg_ok   = (cfg_width >= WB'(2)) && (cfg_height >= WB'(1));
    assign w_line_inc = (r_state == ST_LINE_END);

    jmb_interp_line_cnt #(
        .WB (WB)
    ) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load),
        .i_cfg_w    (cfg_width),
        .i_cfg_h    (cfg_height),
        .i_pix_inc  (w_accept),
        .i_line_inc (w_line_inc),
        .o_pix_one  (w_pix_one),
        .o_pix_tc   (w_pix_tc),
        .o_line_tc  (w_line_tc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        s_ready   = 1'b0;
        w_load    = 1'b0;
        w_accept  = 1'b0;
        w_fire    = 1'b0;
        w_produce = 1'b0;
        w_done    = 1'b0;
        dp_data   = '0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_cfg_ok) begin
                    w_load = 1'b1;
                    w_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                s_ready  = m_ready;
                w_accept = s_valid && m_ready;
                w_fire   = w_accept;
                dp_data  = w_accept ? s_data : '0;
                if (w_accept && w_pix_one) begin
                    w_next = w_pix_tc ? ST_FLUSH1 : ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready   = m_ready;
                w_accept  = s_valid && m_ready;
                w_fire    = w_accept;
                w_produce = w_accept;
                dp_data   = w_accept ? s_data : '0;
                if (w_accept && w_pix_tc) begin
                    w_next = ST_FLUSH1;
                end
            end
            ST_FLUSH1, ST_FLUSH2: begin
                // Replaying the held last pixel closes the interpolation window.
                w_fire    = m_ready;
                w_produce = m_ready;
                dp_data   = m_ready ? r_hold : '0;
                if (m_ready) begin
                    w_next = (r_state == ST_FLUSH1) ? ST_FLUSH2 : ST_LINE_END;
                end
            end
            ST_LINE_END: begin
                if (w_line_tc) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_PRIME;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign dp_valid = w_fire;
    assign dp_ready = w_fire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid      <= 1'b0;
            m_first      <= 1'b0;
            m_last       <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            cfg_err      <= 1'b0;
            r_hold       <= '0;
            r_first_pend <= 1'b0;
        end else begin
            m_valid    <= w_produce;
            m_first    <= w_produce && r_first_pend;
            m_last     <= w_fire && (r_state == ST_FLUSH2);
            frame_done <= w_done;
            cfg_err    <= (r_state == ST_IDLE) && start && !w_cfg_ok;
            if (w_accept) begin
                r_hold <= s_data;
            end
            if (w_load || w_line_inc) begin
                r_first_pend <= 1'b1;
            end else if (w_produce) begin
                r_first_pend <= 1'b0;
            end
            if (w_load) begin
                busy <= 1'b1;
            end else if (w_done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jmb_interp_line_ctrl.sv
// Directed self-checking bench for jmb_interp_line_ctrl with a pair-level
// reference model and a stand-in for the external interpolation datapath.
module tb_jmb_interp_line_ctrl;

    localparam int unsigned WB = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [WB-1:0] cfg_width = '0;
    logic [WB-1:0] cfg_height = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = '0;
    logic          dp_valid;
    logic          dp_ready;
    logic [7:0]    dp_data;
    logic          m_ready = 1'b1;
    logic          m_valid;
    logic          m_first;
    logic          m_last;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       f;
        logic       l;
    } pair_t;

    int         total = 0;
    int         bad = 0;
    pair_t      exp_q[$];
    logic [7:0] src_q[$];
    int         frames_done = 0;
    logic       mon_en = 1'b0;
    int         cur_w = 4;

    logic [7:0] h0 = '0;
    logic [7:0] h1 = '0;
    logic [7:0] pend_a = '0;
    logic [7:0] pend_b = '0;
    logic       exp_mv = 1'b0;
    int         fire_idx = 0;

    jmb_interp_line_ctrl #(
        .WB (WB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .dp_valid   (dp_valid),
        .dp_ready   (dp_ready),
        .dp_data    (dp_data),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_first    (m_first),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Line of pixels -> k-th output pair: (p[k], avg(p[k], p[k+1])), last pixel replicated.
    function automatic pair_t model_pair(input logic [7:0] lp[$], input int k);
        pair_t p;
        int    w;
        int    n;
        w   = lp.size();
        n   = (k + 1 < w) ? k + 1 : w - 1;
        p.a = lp[k];
        p.b = 8'((int'(lp[k]) + int'(lp[n])) / 2);
        p.f = (k == 0);
        p.l = (k == w - 1);
        return p;
    endfunction

    function automatic logic [7:0] pix(input int mode, input int l, input int k);
        case (mode)
            0:       return 8'(10 * (k + 1));
            1:       return (k % 2 == 1) ? 8'd100 : 8'd0;
            default: return 8'((l * 37 + k * 23 + 5) % 256);
        endcase
    endfunction

    // Output monitor: datapath stand-in plus per-cycle comparison against the model.
    initial begin
        pair_t p;
        logic  fire;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                fire_idx = 0;
                exp_mv   = 1'b0;
            end else begin
                chk("m_valid", m_valid, exp_mv);
                if (m_valid) begin
                    chk("pair_avail", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        p = exp_q.pop_front();
                        chk("pair_lo", pend_a, p.a);
                        chk("pair_mid", pend_b, p.b);
                        chk("m_first", m_first, p.f);
                        chk("m_last", m_last, p.l);
                    end
                end
                chk("dp_handshake", dp_ready, dp_valid);
                if (!m_ready) chk("stall_no_fire", dp_valid, 0);
                if (frame_done) begin
                    chk("done_vs_mvalid", m_valid, 0);
                    chk("done_pairs_left", exp_q.size(), 0);
                    frames_done++;
                end
                fire   = dp_valid && dp_ready;
                exp_mv = fire && (fire_idx >= 2);
                if (fire) begin
                    pend_a   = h1;
                    pend_b   = 8'((int'(h1) + int'(h0)) / 2);
                    h1       = h0;
                    h0       = dp_data;
                    fire_idx = (fire_idx == cur_w + 1) ? 0 : fire_idx + 1;
                end
            end
        end
    end

    task automatic chk_zero(input string pfx);
        chk({pfx, "_s_ready"}, s_ready, 0);
        chk({pfx, "_dp_valid"}, dp_valid, 0);
        chk({pfx, "_dp_ready"}, dp_ready, 0);
        chk({pfx, "_dp_data"}, dp_data, 0);
        chk({pfx, "_m_valid"}, m_valid, 0);
        chk({pfx, "_m_first"}, m_first, 0);
        chk({pfx, "_m_last"}, m_last, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_frame_done"}, frame_done, 0);
        chk({pfx, "_cfg_err"}, cfg_err, 0);
    endtask

    // Runs one frame; abort_at>0 returns early (mid-frame) after that many cycles.
    task automatic run_frame(input int w, input int h, input int mode, input int stall,
                             input int rndv, input int dup_start, input int abort_at);
        logic [7:0] lp[$];
        int         fd0;
        int         c;
        logic       acc;
        for (int l = 0; l < h; l++) begin
            lp.delete();
            for (int k = 0; k < w; k++) begin
                lp.push_back(pix(mode, l, k));
                src_q.push_back(pix(mode, l, k));
            end
            for (int k = 0; k < w; k++) exp_q.push_back(model_pair(lp, k));
        end
        cur_w      = w;
        fd0        = frames_done;
        cfg_width  = WB'(w);
        cfg_height = WB'(h);
        m_ready    = 1'b1;
        s_valid    = 1'b0;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        c = 0;
        while (frames_done == fd0 && c < 2000) begin
            m_ready   = stall ? (c % 2 == 0) : 1'b1;
            s_valid   = (src_q.size() > 0) && (rndv ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_data    = (src_q.size() > 0) ? src_q[0] : 8'd0;
            start     = dup_start && (c == 10);
            cfg_width = (dup_start && c >= 10) ? WB'(3) : WB'(w);
            @(negedge clock);
            acc = s_valid && s_ready;
            @(posedge clock);
            #1;
            if (acc) void'(src_q.pop_front());
            c++;
            if (abort_at > 0 && c == abort_at) return;
        end
        s_valid   = 1'b0;
        start     = 1'b0;
        cfg_width = WB'(w);
        chk("frame_completed", frames_done - fd0, 1);
        chk("src_drained", src_q.size(), 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        logic [7:0] lp[$];
        pair_t      p;
        int         lit_a4[4] = '{10, 20, 30, 40};
        int         lit_b4[4] = '{15, 25, 35, 40};
        int         lit_a2[2] = '{0, 100};
        int         lit_b2[2] = '{50, 100};

        // Reset state
        @(posedge clock);
        #2;
        chk_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("release_busy", busy, 0);
        chk("release_done", frame_done, 0);
        chk("release_err", cfg_err, 0);
        mon_en = 1'b1;

        // Hand-computed pins of the model
        lp = {8'd10, 8'd20, 8'd30, 8'd40};
        for (int k = 0; k < 4; k++) begin
            p = model_pair(lp, k);
            chk("pin4_a", p.a, lit_a4[k]);
            chk("pin4_b", p.b, lit_b4[k]);
        end
        lp = {8'd0, 8'd100};
        for (int k = 0; k < 2; k++) begin
            p = model_pair(lp, k);
            chk("pin2_a", p.a, lit_a2[k]);
            chk("pin2_b", p.b, lit_b2[k]);
            chk("pin2_last", p.l, k);
        end

        run_frame(4, 1, 0, 0, 0, 0, 0);
        run_frame(2, 3, 1, 0, 0, 0, 0);
        run_frame(8, 2, 2, 0, 0, 0, 0);
        run_frame(8, 2, 2, 1, 1, 0, 0);

        // Rejected starts
        cfg_width  = WB'(1);
        cfg_height = WB'(1);
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("err_w1_pulse", cfg_err, 1);
        chk("err_w1_busy", busy, 0);
        @(posedge clock);
        #1;
        chk("err_w1_single", cfg_err, 0);
        chk("err_w1_busy2", busy, 0);
        cfg_width  = WB'(4);
        cfg_height = WB'(0);
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("err_h0_pulse", cfg_err, 1);
        chk("err_h0_busy", busy, 0);

        // Start and cfg change while busy must not disturb the frame
        run_frame(8, 1, 2, 0, 0, 1, 0);

        // Reset mid-RUN, then a clean frame
        run_frame(8, 2, 2, 0, 0, 0, 6);
        #1;
        mon_en = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        src_q.delete();
        s_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_zero("postrst");
        mon_en = 1'b1;
        run_frame(4, 1, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jmb_interp_line_ctrl.md
JMB_INTERP_LINE_CTRL -- requirements
Module: jmb_interp_line_ctrl

Interface
REQ-001 Parameter: WB, default 12, bit width of line-width and line-count configuration and counters.
REQ-002 Port: clock  in  1  sole clock; all logic on rising edge.
REQ-003 Port: reset  in  1  reset is asynchronous and active-high.
REQ-004 Port: start  in  1  single-cycle pulse; begins one frame.
REQ-005 Port: cfg_width  in  WB  pixels per line.
REQ-006 Port: cfg_height  in  WB  lines per frame.
REQ-007 Port: s_valid  in  1  upstream pixel valid.
REQ-008 Port: s_ready  out  1  upstream pixel accepted when s_valid&&s_ready.
REQ-009 Port: s_data  in  8  upstream pixel.
REQ-010 Port: dp_valid  out  1  datapath valid_in.
REQ-011 Port: dp_ready  out  1  datapath ready_in.
REQ-012 Port: dp_data  out  8  datapath data_in.
REQ-013 Port: m_ready  in  1  downstream can absorb a pair on the following cycle.
REQ-014 Port: m_valid  out  1  datapath data_out holds a valid pair this cycle.
REQ-015 Port: m_first / m_last  out  1 each  tag first / last pair of a line, qualified by m_valid.
REQ-016 Port: busy  out  1  high from accepted start until frame completes.
REQ-017 Port: frame_done  out  1  single-cycle pulse after last pair of last line.
REQ-018 Port: cfg_err  out  1  single-cycle pulse on rejected start.

Function
REQ-019 Datapath beat ("fire") SHALL be signalled by dp_valid=dp_ready=1 in the same cycle; both low otherwise.
REQ-020 FSM states: IDLE, PRIME, RUN, FLUSH1, FLUSH2, LINE_END.
REQ-021 IDLE: start with cfg_width>=2 and cfg_height>=1 -> latch cfg, clear counters, busy=1, go PRIME; otherwise cfg_err pulse, stay IDLE.
REQ-022 start outside IDLE SHALL be ignored; cfg changes after latch SHALL have no effect until next frame.
REQ-023 PRIME: s_ready=m_ready; fire on s_valid&&s_ready, dp_data=s_data; after 2nd accepted pixel of line -> RUN (or FLUSH1 if cfg_width==2).
REQ-024 RUN: as PRIME; each fire produces one pair; after pixel index cfg_width-1 accepted -> FLUSH1.
REQ-025 FLUSH1/FLUSH2: s_ready=0; fire when m_ready, dp_data = last accepted pixel of line (held register); FLUSH1->FLUSH2->LINE_END.
REQ-026 LINE_END (one cycle, no fire): increment line count; if equals latched cfg_height -> frame_done pulse, busy=0, IDLE; else PRIME.
REQ-027 m_valid SHALL be a registered copy of "fire in RUN, FLUSH1 or FLUSH2", i.e. one cycle after the fire; PRIME fires never raise m_valid.
REQ-028 Exactly cfg_width pairs per line; m_first on first pair (from pixel index 2 fire), m_last on FLUSH2 pair.
REQ-029 Pixel counter and line counter are WB bits, compare with == against latched cfg; no wrap within legal configs.
REQ-030 m_ready low SHALL stall all states without losing pixels; no fire while m_ready=0.
REQ-031 frame_done and m_valid/m_last of final pair SHALL NOT coincide: frame_done asserts in the cycle after LINE_END is entered from the last line.

Reset
REQ-032 Asserting reset at any time SHALL force IDLE immediately; s_ready, dp_valid, dp_ready, m_valid, m_first, m_last, busy, frame_done, cfg_err = 0; dp_data, counters, latched cfg = 0.
REQ-033 Release of reset SHALL not generate any pulse; a partially transferred line is abandoned.

Structure
REQ-034 Shared package jmb_interp_pkg SHALL hold FSM state encoding and the WB default.
REQ-035 One sub-module natural: jmb_interp_line_cnt (pixel/line counters with terminal-count flags); datapath SHALL be instantiated outside this block.

Verification
REQ-036 cfg 4x1, pixels 10,20,30,40, m_ready=1 -> 4 m_valid pulses, datapath outputs (10,15),(20,25),(30,35),(40,40); m_first on 1st, m_last on 4th, one frame_done.
REQ-037 cfg_width=2, height=3, pixels 0,100 per line -> per line pairs (0,50),(100,100); 6 pairs, 3 m_last, frame_done once.
REQ-038 cfg 8x2, m_ready toggled 1/0 each cycle, s_valid random -> same 16 pairs in order as unstalled run, no fire while m_ready=0.
REQ-039 start with cfg_width=1 -> cfg_err pulse, busy stays 0; start during busy -> no effect on pair count.
REQ-040 Reset asserted mid-RUN of 8x2 frame -> all outputs 0 same cycle; new start 4x1 after release yields exactly REQ-036 sequence.
